btn_click_decoder: RTL and testbench

Consumes the single-cycle press pulse from the button debouncer and classifies bursts of presses into multi-click events: single, double, triple, up to MAX_CLICKS. Sits between the debouncer and the control logic that steps demo modes. Each completed burst is offered to that logic as one event on a valid/ready output.

---
 rtl/btn_pkg.sv | 9 +
 rtl/btn_click_decoder.sv | 100 ++++++++++
 tb/tb_btn_click_decoder.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/btn_pkg.sv
// Shared types and widths for the button click decoder.
package btn_pkg;

    typedef enum logic [1:0] {IDLE, COUNT, EMIT} click_state_t;

    localparam int CLICK_W = 3;
    localparam int TIMER_W = 24;

endpackage

// File: rtl/btn_click_decoder.sv
// Groups debounced press pulses into 1..MAX_CLICKS click bursts; a burst ends on window
// expiry or on reaching MAX_CLICKS, and is held on evt_valid until accepted.
module btn_click_decoder
    import btn_pkg::*;
#(
    parameter int WINDOW     = 5_000_000,
    parameter int MAX_CLICKS = 3
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               press,
    output logic               evt_valid,
    input  logic               evt_ready,
    output logic [CLICK_W-1:0] evt_clicks,
    output logic               evt_drop
);

    localparam logic [TIMER_W-1:0] RELOAD = TIMER_W'(WINDOW - 1);
    localparam logic [CLICK_W-1:0] MAX_C  = CLICK_W'(MAX_CLICKS);

    click_state_t       state;
    click_state_t       state_nxt;
    logic [CLICK_W-1:0] clicks;
    logic [CLICK_W-1:0] clicks_inc;
    logic [TIMER_W-1:0] timer;
    logic               last_click;

    assign clicks_inc = clicks + CLICK_W'(1);
    assign last_click = (clicks_inc == MAX_C);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Click counter, window timer and drop flag share the state decode.
    always_ff @(posedge clk) begin
        if (reset) begin
            clicks   <= '0;
            timer    <= '0;
            evt_drop <= 1'b0;
        end else begin
            evt_drop <= (state == EMIT) && press;
            case (state)
                IDLE: begin
                    if (press) begin
                        clicks <= CLICK_W'(1);
                        timer  <= RELOAD;
                    end
                end
                COUNT: begin
                    if (press) begin
                        clicks <= last_click ? MAX_C : clicks_inc;
                        timer  <= RELOAD;
                    end else if (timer != '0) begin
                        timer <= timer - TIMER_W'(1);
                    end
                end
                EMIT: begin
                    if (evt_ready) begin
                        clicks <= '0;
                    end
                end
                default: begin
                    clicks <= '0;
                end
            endcase
        end
    end

    // A press coinciding with timer==0 takes priority over window expiry.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (press) state_nxt = COUNT;
            end
            COUNT: begin
                if (press) begin
                    if (last_click) state_nxt = EMIT;
                end else if (timer == '0) begin
                    state_nxt = EMIT;
                end
            end
            EMIT: begin
                if (evt_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        evt_valid  = (state == EMIT);
        evt_clicks = (state == EMIT) ? clicks : '0;
    end

endmodule

// File: tb/tb_btn_click_decoder.sv
// Scenario bench for btn_click_decoder with WINDOW=8, MAX_CLICKS=3.
module tb_btn_click_decoder;

    typedef struct {
        int         first;
        int         last;
        logic [2:0] clicks;
    } exp_evt_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       press = 1'b0;
    logic       evt_ready = 1'b1;
    logic       evt_valid;
    logic [2:0] evt_clicks;
    logic       evt_drop;

    int       cyc = 0;
    int       vectors = 0;
    int       miscompares = 0;
    bit       mon_en = 1'b0;
    exp_evt_t exp_q[$];

    btn_click_decoder #(.WINDOW(8), .MAX_CLICKS(3)) dut (
        .clk        (clk),
        .reset      (reset),
        .press      (press),
        .evt_valid  (evt_valid),
        .evt_ready  (evt_ready),
        .evt_clicks (evt_clicks),
        .evt_drop   (evt_drop)
    );

    always #5 clk = ~clk;

    // Scoreboard: events are popped when the DUT presents them.
    always @(negedge clk) begin
        if (mon_en) begin
            if (evt_valid) begin
                vectors++;
                if (exp_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL spurious_evt cyc=%0d got clicks=%0d, expected no event", cyc, evt_clicks);
                end else if (cyc < exp_q[0].first || evt_clicks !== exp_q[0].clicks) begin
                    miscompares++;
                    $display("FAIL evt cyc=%0d got clicks=%0d, expected clicks=%0d in cycles %0d..%0d",
                             cyc, evt_clicks, exp_q[0].clicks, exp_q[0].first, exp_q[0].last);
                    if (evt_ready) void'(exp_q.pop_front());
                end else if (evt_ready) begin
                    if (cyc != exp_q[0].last) begin
                        miscompares++;
                        $display("FAIL evt_accept got cycle %0d, expected cycle %0d", cyc, exp_q[0].last);
                    end
                    void'(exp_q.pop_front());
                end
            end else if (exp_q.size() != 0 && cyc >= exp_q[0].first) begin
                vectors++;
                miscompares++;
                $display("FAIL evt_missing cyc=%0d got evt_valid=0, expected clicks=%0d from cycle %0d",
                         cyc, exp_q[0].clicks, exp_q[0].first);
                void'(exp_q.pop_front());
            end
        end
    end

    task automatic do_reset();
        mon_en = 1'b0;
        exp_q.delete();
        press = 1'b0;
        evt_ready = 1'b1;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        cyc = 0;
        mon_en = 1'b1;
    endtask

    task automatic drive(input logic p, input logic r, input logic rst);
        press = p;
        evt_ready = r;
        reset = rst;
        @(negedge clk);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic test_reset();
        do_reset();
        drive(1'b0, 1'b1, 1'b0);
        vectors++;
        if (evt_valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid got %b, expected 0", evt_valid); end
        vectors++;
        if (evt_clicks !== 3'd0) begin miscompares++; $display("FAIL reset_clicks got %0d, expected 0", evt_clicks); end
        vectors++;
        if (evt_drop !== 1'b0) begin miscompares++; $display("FAIL reset_drop got %b, expected 0", evt_drop); end
        tick();
    endtask

    task automatic test_single();
        do_reset();
        exp_q.push_back('{19, 19, 3'd1});
        for (int c = 0; c < 30; c++) begin
            drive(c == 10, 1'b1, 1'b0);
            vectors++;
            if (evt_drop !== 1'b0) begin miscompares++; $display("FAIL single_drop cyc=%0d got 1, expected 0", cyc); end
            tick();
        end
        vectors++;
        if (exp_q.size() != 0) begin miscompares++; $display("FAIL single_pending got %0d, expected 0", exp_q.size()); end
    endtask

    task automatic test_double();
        do_reset();
        exp_q.push_back('{24, 24, 3'd2});
        for (int c = 0; c < 35; c++) begin
            drive(c == 10 || c == 15, 1'b1, 1'b0);
            tick();
        end
        vectors++;
        if (exp_q.size() != 0) begin miscompares++; $display("FAIL double_pending got %0d, expected 0", exp_q.size()); end
    endtask

    task automatic test_coincident_expiry();
        do_reset();
        exp_q.push_back('{27, 27, 3'd2});
        for (int c = 0; c < 40; c++) begin
            drive(c == 10 || c == 18, 1'b1, 1'b0);
            tick();
        end
        vectors++;
        if (exp_q.size() != 0) begin miscompares++; $display("FAIL coincident_pending got %0d, expected 0", exp_q.size()); end
    endtask

    task automatic test_triple();
        do_reset();
        exp_q.push_back('{15, 15, 3'd3});
        for (int c = 0; c < 30; c++) begin
            drive(c == 10 || c == 12 || c == 14, 1'b1, 1'b0);
            tick();
        end
        vectors++;
        if (exp_q.size() != 0) begin miscompares++; $display("FAIL triple_pending got %0d, expected 0", exp_q.size()); end
    endtask

    task automatic test_backpressure();
        do_reset();
        exp_q.push_back('{19, 30, 3'd1});
        exp_q.push_back('{40, 40, 3'd1});
        for (int c = 0; c < 46; c++) begin
            drive(c == 10 || c == 22 || c == 31, c >= 30, 1'b0);
            vectors++;
            if (evt_drop !== (cyc == 23)) begin
                miscompares++;
                $display("FAIL bp_drop cyc=%0d got %b, expected %b", cyc, evt_drop, cyc == 23);
            end
            tick();
        end
        vectors++;
        if (exp_q.size() != 0) begin miscompares++; $display("FAIL bp_pending got %0d, expected 0", exp_q.size()); end
    endtask

    // Press on the handshake cycle is dropped; the very next cycle starts a new burst.
    task automatic test_back_to_back();
        do_reset();
        exp_q.push_back('{15, 15, 3'd3});
        exp_q.push_back('{25, 25, 3'd1});
        for (int c = 0; c < 35; c++) begin
            drive(c == 10 || c == 12 || c == 14 || c == 15 || c == 16, 1'b1, 1'b0);
            vectors++;
            if (evt_drop !== (cyc == 16)) begin
                miscompares++;
                $display("FAIL b2b_drop cyc=%0d got %b, expected %b", cyc, evt_drop, cyc == 16);
            end
            tick();
        end
        vectors++;
        if (exp_q.size() != 0) begin miscompares++; $display("FAIL b2b_pending got %0d, expected 0", exp_q.size()); end
    endtask

    task automatic test_reset_mid_burst();
        do_reset();
        exp_q.push_back('{29, 29, 3'd1});
        for (int c = 0; c < 41; c++) begin
            drive(c == 10 || c == 12 || c == 14 || c == 20, 1'b1, c == 14);
            vectors++;
            if (evt_drop !== 1'b0) begin miscompares++; $display("FAIL rst_drop cyc=%0d got 1, expected 0", cyc); end
            if (cyc == 15) begin
                vectors++;
                if (evt_clicks !== 3'd0 || evt_valid !== 1'b0) begin
                    miscompares++;
                    $display("FAIL rst_outputs got valid=%b clicks=%0d, expected 0/0", evt_valid, evt_clicks);
                end
            end
            tick();
        end
        vectors++;
        if (exp_q.size() != 0) begin miscompares++; $display("FAIL rst_pending got %0d, expected 0", exp_q.size()); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_double();
        test_coincident_expiry();
        test_triple();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_burst();
        mon_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
